// File: rtl/kf_fxp_pkg.sv
// Shared fixed-point definitions for the Kalman filter stages: default Q format,
// predict-stage FSM encodings and the plain 2N->N truncate.
package kf_fxp_pkg;
  localparam int N_DEF    = 20;
  localparam int FRAC_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5
  } state_t;

  // Slice keeps floor rounding for free since the product is two's complement.
  function automatic logic [N_DEF-1:0] fxp_trunc(input logic [2*N_DEF-1:0] v);
    return v[FRAC_DEF+N_DEF-1:FRAC_DEF];
  endfunction
endpackage

// File: rtl/prior_trunc_sat.sv
// 2N product-domain value back to N-bit Q format (floor rounding).
// Define PRIOR_SAT_EN to clamp out-of-range values instead of wrapping.
module prior_trunc_sat
  import kf_fxp_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [2*N-1:0] v,
  output logic [N-1:0]   t
);
`ifdef PRIOR_SAT_EN
  // In range only if every bit above the result's sign bit copies it.
  logic [N-FRAC:0] upper;
  logic            fits;
  logic            unused_frac;

  assign upper       = v[2*N-1:FRAC+N-1];
  assign fits        = (&upper) | ~(|upper);
  assign unused_frac = ^v[FRAC-1:0];

  always_comb begin
    if (fits)
      t = v[FRAC+N-1:FRAC];
    else if (v[2*N-1])
      t = {1'b1, {(N-1){1'b0}}};
    else
      t = {1'b0, {(N-1){1'b1}}};
  end
`else
  logic unused_bits;

  assign unused_bits = ^{v[2*N-1:FRAC+N], v[FRAC-1:0]};
  assign t           = v[FRAC+N-1:FRAC];
`endif
endmodule

// File: rtl/prior_state_serial.sv
// Serial Kalman predict stage: x_prior = F*x_post + B*u, z_hat = H*x_prior, using
// two shared multipliers over a 6-cycle schedule. PRIOR_SAT_EN selects saturating T().
module prior_state_serial
  import kf_fxp_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x00_post,
  input  logic [N-1:0] x10_post,
  input  logic [N-1:0] f00,
  input  logic [N-1:0] f01,
  input  logic [N-1:0] f10,
  input  logic [N-1:0] f11,
  input  logic [N-1:0] b00,
  input  logic [N-1:0] b10,
  input  logic [N-1:0] u,
  input  logic [N-1:0] h00,
  input  logic [N-1:0] h01,
  input  logic [N-1:0] h10,
  input  logic [N-1:0] h11,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] X00_prior,
  output logic [N-1:0] X10_prior,
  output logic [N-1:0] Z00_hat,
  output logic [N-1:0] Z10_hat
);
  state_t         state;
  logic [N-1:0]   sx0, sx1, sf10, sf11, sb00, sb10, su;
  logic [N-1:0]   sh00, sh01, sh10, sh11;
  logic [N-1:0]   m0a, m0b, m1a, m1b;
  logic [2*N-1:0] acc0, acc1;
  logic [2*N-1:0] m0_full, m1_full, s, p0, p1;
  logic [N-1:0]   t_p0, t_p1, t_s;

  // Explicit sign extension keeps the low 2N bits equal to the signed product.
  assign m0_full = {{N{m0a[N-1]}}, m0a} * {{N{m0b[N-1]}}, m0b};
  assign m1_full = {{N{m1a[N-1]}}, m1a} * {{N{m1b[N-1]}}, m1b};
  assign s       = m0_full + m1_full;
  assign p0      = acc0 + m0_full;
  assign p1      = acc1 + m1_full;

  prior_trunc_sat #(.N(N), .FRAC(FRAC)) u_trunc_p0 (.v(p0), .t(t_p0));
  prior_trunc_sat #(.N(N), .FRAC(FRAC)) u_trunc_p1 (.v(p1), .t(t_p1));
  prior_trunc_sat #(.N(N), .FRAC(FRAC)) u_trunc_s  (.v(s),  .t(t_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      X00_prior <= '0;
      X10_prior <= '0;
      Z00_hat   <= '0;
      Z10_hat   <= '0;
      sx0       <= '0;
      sx1       <= '0;
      sf10      <= '0;
      sf11      <= '0;
      sb00      <= '0;
      sb10      <= '0;
      su        <= '0;
      sh00      <= '0;
      sh01      <= '0;
      sh10      <= '0;
      sh11      <= '0;
      m0a       <= '0;
      m0b       <= '0;
      m1a       <= '0;
      m1b       <= '0;
      acc0      <= '0;
      acc1      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sx0   <= x00_post;
            sx1   <= x10_post;
            sf10  <= f10;
            sf11  <= f11;
            sb00  <= b00;
            sb10  <= b10;
            su    <= u;
            sh00  <= h00;
            sh01  <= h01;
            sh10  <= h10;
            sh11  <= h11;
            m0a   <= f00;
            m0b   <= x00_post;
            m1a   <= f01;
            m1b   <= x10_post;
            busy  <= 1'b1;
            state <= ST_S1;
          end
        end
        ST_S1: begin
          acc0  <= s;
          m0a   <= sf10;
          m0b   <= sx0;
          m1a   <= sf11;
          m1b   <= sx1;
          state <= ST_S2;
        end
        ST_S2: begin
          acc1  <= s;
          m0a   <= sb00;
          m0b   <= su;
          m1a   <= sb10;
          m1b   <= su;
          state <= ST_S3;
        end
        ST_S3: begin
          // H sees the same truncated x_prior that is handed downstream.
          X00_prior <= t_p0;
          X10_prior <= t_p1;
          m0a       <= sh00;
          m0b       <= t_p0;
          m1a       <= sh01;
          m1b       <= t_p1;
          state     <= ST_S4;
        end
        ST_S4: begin
          Z00_hat <= t_s;
          m0a     <= sh10;
          m0b     <= X00_prior;
          m1a     <= sh11;
          m1b     <= X10_prior;
          state   <= ST_S5;
        end
        ST_S5: begin
          Z10_hat <= t_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prior_state_serial.sv
// Directed bench for prior_state_serial (N=20, FRAC=10); expectations are hand-computed.
module tb_prior_state_serial;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [19:0] x00_post, x10_post, f00, f01, f10, f11, b00, b10, u;
  logic [19:0] h00, h01, h10, h11;
  logic        busy, done;
  logic [19:0] X00_prior, X10_prior, Z00_hat, Z10_hat;

  int tests = 0;
  int fails = 0;

  prior_state_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x00_post(x00_post), .x10_post(x10_post),
    .f00(f00), .f01(f01), .f10(f10), .f11(f11),
    .b00(b00), .b10(b10), .u(u),
    .h00(h00), .h01(h01), .h10(h10), .h11(h11),
    .busy(busy), .done(done),
    .X00_prior(X00_prior), .X10_prior(X10_prior),
    .Z00_hat(Z00_hat), .Z10_hat(Z10_hat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [19:0] ix0, ix1, if00, if01, if10, if11,
                        ib00, ib10, iu, ih00, ih01, ih10, ih11);
    x00_post = ix0;  x10_post = ix1;
    f00 = if00; f01 = if01; f10 = if10; f11 = if11;
    b00 = ib00; b10 = ib10; u = iu;
    h00 = ih00; h01 = ih01; h10 = ih10; h11 = ih11;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits for done; lat_exp counts edges from the current position.
  task automatic wait_done(input string tag, input int lat_exp);
    int lat;
    lat = 99;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat[19:0], lat_exp[19:0]);
  endtask

  task automatic check_out(input string tag, input logic [19:0] ex0, ex1, ez0, ez1);
    chk({tag, "_X00"}, X00_prior, ex0);
    chk({tag, "_X10"}, X10_prior, ex1);
    chk({tag, "_Z00"}, Z00_hat, ez0);
    chk({tag, "_Z10"}, Z10_hat, ez1);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done) n++;
    end
  endtask

  initial begin
    int          n;
    logic [19:0] seen;

    rst_n = 1'b0;
    start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_out("reset", 0, 0, 0, 0);
    chk("reset_busy", {19'd0, busy}, 0);
    chk("reset_done", {19'd0, done}, 0);
    rst_n = 1'b1;
    step();

    // Identity: cycle-by-cycle schedule of outputs, busy and done
    set_in(2048, -1024, 1024, 0, 0, 1024, 0, 0, 0, 1024, 0, 0, 1024);
    pulse_start();
    chk("id_e0_busy", {19'd0, busy}, 1);
    chk("id_e0_done", {19'd0, done}, 0);
    step();
    step();
    chk("id_e2_X00_old", X00_prior, 0);
    step();
    chk("id_e3_X00", X00_prior, 2048);
    chk("id_e3_X10", X10_prior, -1024);
    chk("id_e3_Z00_old", Z00_hat, 0);
    chk("id_e3_done", {19'd0, done}, 0);
    step();
    chk("id_e4_Z00", Z00_hat, 2048);
    chk("id_e4_Z10_old", Z10_hat, 0);
    chk("id_e4_busy", {19'd0, busy}, 1);
    step();
    chk("id_e5_Z10", Z10_hat, -1024);
    chk("id_e5_done", {19'd0, done}, 1);
    chk("id_e5_busy", {19'd0, busy}, 0);
    step();
    chk("id_e6_done", {19'd0, done}, 0);
    check_out("id_hold", 2048, -1024, 2048, -1024);

    // Constant velocity, with every input scrambled right after edge 0
    set_in(1024, 512, 1024, 1024, 0, 1024, 512, 1024, 1024, 1024, 0, 0, 0);
    pulse_start();
    set_in(777, -777, 333, 333, 333, 333, 333, 333, 333, 333, 333, 333, 333);
    wait_done("cv", 5);
    check_out("cv", 2048, 1536, 2048, 0);

    // One-cycle start at edge 2 while busy is ignored
    set_in(2048, -1024, 1024, 0, 0, 1024, 0, 0, 0, 1024, 0, 0, 1024);
    pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign", 3);
    check_out("ign", 2048, -1024, 2048, -1024);
    count_done(10, n);
    chk("ign_extra_done", n[19:0], 0);
    chk("ign_busy_idle", {19'd0, busy}, 0);

    // start held high: done after edges 5, 11 and 17
    set_in(1024, 512, 1024, 1024, 0, 1024, 512, 1024, 1024, 1024, 0, 0, 0);
    seen  = '0;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (done) seen[i] = 1'b1;
    end
    start = 1'b0;
    chk("b2b_done_edges", seen, 20'h20820);
    check_out("b2b", 2048, 1536, 2048, 0);
    step();
    step();

    // Overflow of X00: 4096*262144 = 2^30 -> 2^20 after truncation
    set_in(262144, 0, 4096, 0, 0, 1024, 0, 0, 0, 1024, 0, 0, 1024);
    pulse_start();
    wait_done("ovf", 5);
`ifdef PRIOR_SAT_EN
    check_out("ovf", 524287, 0, 524287, 0);
`else
    check_out("ovf", 0, 0, 0, 0);
`endif

    // Floor truncation: 512 * -1 = -512 -> -1, not 0
    set_in(-1, 0, 512, 0, 0, 0, 0, 0, 0, 1024, 0, 0, 1024);
    pulse_start();
    wait_done("floor", 5);
    check_out("floor", -1, 0, -1, 0);

    // Reset while in S3, then a clean run
    set_in(2048, -1024, 1024, 0, 0, 1024, 0, 0, 0, 1024, 0, 0, 1024);
    pulse_start();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_out("rst_mid", 0, 0, 0, 0);
    chk("rst_mid_busy", {19'd0, busy}, 0);
    chk("rst_mid_done", {19'd0, done}, 0);
    step();
    rst_n = 1'b1;
    count_done(8, n);
    chk("rst_no_done", n[19:0], 0);
    chk("rst_out_zero", X00_prior, 0);
    pulse_start();
    wait_done("after_rst", 5);
    check_out("after_rst", 2048, -1024, 2048, -1024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
